cia_tod: RTL and testbench
==========================

Name: cia_tod

Overview:
Time Of Day clock for the CIA core: the 10ths/sec/min/hr BCD counter chain, its 50/60 Hz prescaler, the alarm registers, the read latch and the write-stop logic.
- Downstream of the TOD input pin; upstream of the register read mux and the ICR.
- Produces the `cia::tod_t` register image, read data for addresses 0x8-0xB, and the ALRM interrupt request pulse.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on the asynchronous TOD pin (minimum 2).

Ports:
- clk  input  1  system clock.
- res_n  input  1  reset; asynchronous, active-low.
- ce  input  1  one-clk strobe per phi2 cycle; all architectural state updates only when ce=1.
- tod_pin  input  1  raw TOD pin (50/60 Hz); asynchronous to clk.
- todin  input  1  CRA.todin; 0 selects divide-by-6 (60 Hz), 1 selects divide-by-5 (50 Hz).
- alarm_sel  input  1  CRB.alarm; 1 routes writes to the alarm registers.
- we  input  1  register write strobe, qualified by ce.
- re  input  1  register read strobe, qualified by ce.
- addr  input  2  register offset: 0 = 10ths, 1 = sec, 2 = min, 3 = hr.
- data_i  input  8  write data.
- data_o  output  8  read data for addr.
- tod_o  output  32  live counter, type `cia::tod_t`, unused bits zero.
- alrm_int  output  1  one-ce-cycle pulse when the counter becomes equal to the alarm.

Behaviour:
Reset:
- Counter resets to hr=0x01 (AM), min=0x00, sec=0x00, 10ths=0x0.
- Alarm registers reset to all zero.
- Prescaler resets to 0; state is running; read latch is released.
- data_o=0, alrm_int=0.

TOD pin:
- tod_pin passes through a SYNC_STAGES synchronizer.
- A rising edge is detected in clk and held pending until the next ce.
- Each pending edge increments the 3-bit prescaler, but only while the clock is running.
- When the prescaler reaches 5 (todin=0) or 4 (todin=1), it clears to 0 and generates a tick on the same ce.
- If todin changes mid-count with prescaler >= the new terminal value, the prescaler clears on the next edge and generates a tick.

Tick (all carries resolve in one ce cycle):
- 10ths 0-9 wraps to 0 and carries into sec.
- sec 00-59 wraps and carries into min.
- min 00-59 wraps and carries into hr.
- hr counts 01..12 in BCD. 11->12 toggles pm; 12->01 leaves pm unchanged.
- Illegal BCD values (written by software) increment in binary within their nibble: a low nibble of 0xF wraps to 0 without carry. Sequences must match a nibble-wise incrementer with compare-to-9/5/12.

Writes (we & ce):
- alarm_sel=0 targets the counter; alarm_sel=1 targets the alarm. Field masks: 10ths [3:0], sec/min [6:0], hr {pm, hh, hl}.
- Counter write to hr: stops the clock and clears the prescaler.
- Counter write to 10ths: restarts the clock. The first tick requires a full prescaler period.
- Counter writes to sec/min do not change the run state.
- Alarm writes never stop the clock.

Reads (re & ce):
- Reading hr freezes a snapshot of all four counter registers; data_o comes from the snapshot until 10ths is read.
- Reading 10ths releases the latch after returning the snapshot value.
- data_o is registered and valid the clk after re&ce.
- Unused bits read 0; the alarm registers are write-only.

Alarm:
- eq = (counter == alarm) over the full 32-bit masked image, evaluated after each ce update.
- alrm_int pulses for one ce cycle on a 0->1 transition of eq, whether caused by a tick, a counter write or an alarm write.
- eq staying high produces no further pulses.

Simultaneous events:
- A counter write and a tick in the same ce: the write wins for the written field. Carries into other fields are still applied.
- re and we in the same ce: the write applies and the read returns the pre-write value.

Optional Feature:
CIA_TOD_HR12_QUIRK_EN:
- Defined: a counter write (alarm_sel=0) of an hr value whose hh/hl field is 12 stores the pm bit inverted, matching MOS6526 silicon. Example: writing 0x92 stores 0x12.
- Undefined: pm is stored exactly as written.
- Alarm writes are never affected.

Test Plan:
1. Reset, todin=0, 6 tod_pin edges -> tod_o 10ths=1; a 5th-edge-only run leaves 10ths=0.
2. Write hr=0x11 (stop), min=0x59, sec=0x59, 10ths=0x9 (start), todin=1, 5 edges -> hr=0x92, min=0, sec=0, 10ths=0. Next wrap from 12:59:59.9 -> hr=0x81.
3. Write hr=0x05, then 12 tod_pin edges, then write 10ths=0 -> counter unchanged while stopped; runs after restart.
4. Read hr (0x03), advance 20 ticks, read sec/min -> values unchanged from snapshot; read 10ths releases; next read returns live values.
5. Alarm write hr=0x01, min=0, sec=0, 10ths=1 after reset -> alrm_int pulses exactly once after the first tick; no second pulse while equal.
6. Macro defined: counter write hr=0x92 -> tod_o hr=0x12. Macro undefined -> tod_o hr=0x92. Alarm write 0x92 stores 0x92 in both builds.

Source files
------------

// File: rtl/cia_tod.sv
// rtl/cia_tod.sv - CIA time-of-day clock: BCD counter chain, 50/60 Hz prescaler, alarm, read latch
// Optional: define CIA_TOD_HR12_QUIRK_EN to invert pm on counter writes of hour 12.
module cia_tod #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        ce,
  input  logic        tod_pin,
  input  logic        todin,
  input  logic        alarm_sel,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  addr,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic [31:0] tod_o,
  output logic        alrm_int
);

  // Image layout: [31:24] hr {pm,00,hh,hl}, [23:16] min, [15:8] sec, [7:0] 10ths.
  localparam logic [31:0] CNT_RESET = 32'h0100_0000;

  logic [SYNC_STAGES-1:0] r_sync;
  logic        r_pin_q, r_pend, r_run, r_latch, r_eq;
  logic [2:0]  r_presc;
  logic [31:0] r_cnt, r_alm, r_snap;

  logic        w_rise, w_edge, w_tick, w_cnt_wr, w_alm_wr, w_eq_next;
  logic [2:0]  w_term;
  logic [4:0]  w_shift;
  logic [7:0]  w_mbyte, w_abyte, w_cbyte, w_rbyte;
  logic [31:0] w_mask, w_cpos, w_apos, w_cnt_tk, w_cnt_next, w_alm_next, w_rsrc;

  function automatic logic [31:0] tod_inc(input logic [31:0] t);
    logic [3:0] tl, sl, ml, hl;
    logic [2:0] sh, mh;
    logic       hh, pm, c0, c1, c2, c3, c4;
    tl = t[3:0];   sl = t[11:8];  sh = t[14:12];
    ml = t[19:16]; mh = t[22:20]; hl = t[27:24]; hh = t[28]; pm = t[31];
    c0 = (tl == 4'd9);
    tl = c0 ? 4'd0 : tl + 4'd1;
    c1 = c0 & (sl == 4'd9);
    if (c0) sl = c1 ? 4'd0 : sl + 4'd1;
    c2 = c1 & (sh == 3'd5);
    if (c1) sh = c2 ? 3'd0 : sh + 3'd1;
    c3 = c2 & (ml == 4'd9);
    if (c2) ml = c3 ? 4'd0 : ml + 4'd1;
    c4 = c3 & (mh == 3'd5);
    if (c3) mh = c4 ? 3'd0 : mh + 3'd1;
    if (c4) begin
      if ({hh, hl} == 5'h12) begin
        {hh, hl} = 5'h01;
      end else if ({hh, hl} == 5'h11) begin
        {hh, hl} = 5'h12;
        pm = ~pm;
      end else if (hl == 4'd9) begin
        hl = 4'd0;
        hh = ~hh;
      end else begin
        hl = hl + 4'd1;
      end
    end
    return {pm, 2'b00, hh, hl, 1'b0, mh, ml, 1'b0, sh, sl, 4'h0, tl};
  endfunction

  assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_pin_q;
  assign w_edge   = r_pend | w_rise;
  assign w_term   = todin ? 3'd4 : 3'd5;
  assign w_tick   = ce & w_edge & r_run & (r_presc >= w_term);
  assign w_cnt_wr = ce & we & ~alarm_sel;
  assign w_alm_wr = ce & we & alarm_sel;
  assign w_shift  = {addr, 3'b000};

  always_comb begin
    w_mbyte = 8'h0F;
    case (addr)
      2'd1, 2'd2: w_mbyte = 8'h7F;
      2'd3:       w_mbyte = 8'h9F;
      default:    w_mbyte = 8'h0F;
    endcase
    w_abyte = data_i & w_mbyte;
    w_cbyte = w_abyte;
`ifdef CIA_TOD_HR12_QUIRK_EN
    if (addr == 2'd3 && data_i[4:0] == 5'h12) w_cbyte[7] = ~data_i[7];
`endif
  end

  assign w_mask     = {24'h0, w_mbyte} << w_shift;
  assign w_cpos     = {24'h0, w_cbyte} << w_shift;
  assign w_apos     = {24'h0, w_abyte} << w_shift;
  // The tick carries through every field; a same-cycle write then overrides only its own field.
  assign w_cnt_tk   = w_tick ? tod_inc(r_cnt) : r_cnt;
  assign w_cnt_next = w_cnt_wr ? ((w_cnt_tk & ~w_mask) | w_cpos) : w_cnt_tk;
  assign w_alm_next = w_alm_wr ? ((r_alm & ~w_mask) | w_apos) : r_alm;
  assign w_eq_next  = (w_cnt_next == w_alm_next);
  assign w_rsrc     = r_latch ? r_snap : r_cnt;

  always_comb begin
    w_rbyte = w_rsrc[7:0];
    case (addr)
      2'd1:    w_rbyte = w_rsrc[15:8];
      2'd2:    w_rbyte = w_rsrc[23:16];
      2'd3:    w_rbyte = w_rsrc[31:24];
      default: w_rbyte = w_rsrc[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_sync   <= '0;
      r_pin_q  <= 1'b0;
      r_pend   <= 1'b0;
      r_presc  <= 3'd0;
      r_run    <= 1'b1;
      r_cnt    <= CNT_RESET;
      r_alm    <= 32'h0;
      r_snap   <= 32'h0;
      r_latch  <= 1'b0;
      r_eq     <= 1'b0;
      data_o   <= 8'h00;
      alrm_int <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], tod_pin};
      r_pin_q <= r_sync[SYNC_STAGES-1];
      if (ce) r_pend <= 1'b0;
      else if (w_rise) r_pend <= 1'b1;
      if (ce) begin
        r_cnt    <= w_cnt_next;
        r_alm    <= w_alm_next;
        r_eq     <= w_eq_next;
        alrm_int <= w_eq_next & ~r_eq;
        if (w_cnt_wr && (addr == 2'd3 || addr == 2'd0)) begin
          r_presc <= 3'd0;
          r_run   <= (addr == 2'd0);
        end else if (w_edge && r_run) begin
          r_presc <= (r_presc >= w_term) ? 3'd0 : r_presc + 3'd1;
        end
        if (re) begin
          data_o <= w_rbyte;
          if (addr == 2'd3 && !r_latch) begin
            r_snap  <= r_cnt;
            r_latch <= 1'b1;
          end else if (addr == 2'd0) begin
            r_latch <= 1'b0;
          end
        end
      end
    end
  end

  assign tod_o = r_cnt;

endmodule

// File: tb/tb_cia_tod.sv
// tb/tb_cia_tod.sv - directed bench for cia_tod
module tb_cia_tod;

`ifdef CIA_TOD_HR12_QUIRK_EN
  localparam bit QUIRK = 1'b1;
`else
  localparam bit QUIRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        ce = 1'b0;
  logic        tod_pin = 1'b0;
  logic        todin = 1'b0;
  logic        alarm_sel = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  data_o;
  logic [31:0] tod_o;
  logic        alrm_int;

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;

  cia_tod #(.SYNC_STAGES(2)) dut (
    .clk(clk), .res_n(res_n), .ce(ce), .tod_pin(tod_pin), .todin(todin),
    .alarm_sel(alarm_sel), .we(we), .re(re), .addr(addr), .data_i(data_i),
    .data_o(data_o), .tod_o(tod_o), .alrm_int(alrm_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hr, mn, sc, t10;
    logic        tin;
    int          edges;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // One ce cycle followed by one idle clk; outputs sampled 1 time unit after edges.
  task automatic cyc();
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; re = 1'b0;
    if (alrm_int) pulses++;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] a, input logic [7:0] d);
    alarm_sel = sel; addr = a; data_i = d; we = 1'b1;
    cyc();
  endtask

  task automatic rd(input logic [1:0] a);
    alarm_sel = 1'b0; addr = a; re = 1'b1;
    cyc();
  endtask

  task automatic pin_edges(input int n);
    for (int i = 0; i < n; i++) begin
      tod_pin = 1'b1;
      repeat (3) cyc();
      tod_pin = 1'b0;
      repeat (3) cyc();
    end
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    repeat (2) cyc();
    res_n = 1'b1;
    cyc();
  endtask

  initial begin
    tbl[0]  = '{8'h11, 8'h59, 8'h59, 8'h09, 1'b1, 5,  32'h9200_0000};
    tbl[1]  = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 6,  32'h0100_0001};
    tbl[2]  = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 5,  32'h0100_0000};
    tbl[3]  = '{8'h09, 8'h59, 8'h59, 8'h09, 1'b1, 5,  32'h1000_0000};
    tbl[4]  = '{8'h12, 8'h59, 8'h59, 8'h09, 1'b1, 5,  QUIRK ? 32'h8100_0000 : 32'h0100_0000};
    tbl[5]  = '{8'h01, 8'h00, 8'h00, 8'hFF, 1'b1, 5,  32'h0100_0000};
    tbl[6]  = '{8'h01, 8'h00, 8'h3F, 8'h09, 1'b1, 5,  32'h0100_3000};
    tbl[7]  = '{8'h01, 8'h4A, 8'h59, 8'h09, 1'b1, 5,  32'h014B_0000};
    tbl[8]  = '{8'h01, 8'h22, 8'h79, 8'h09, 1'b1, 5,  32'h0122_0000};
    tbl[9]  = '{8'h19, 8'h59, 8'h59, 8'h09, 1'b1, 5,  32'h0000_0000};
    tbl[10] = '{8'h85, 8'h23, 8'h45, 8'h06, 1'b0, 6,  32'h8523_4507};
    tbl[11] = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 10, 32'h0100_0002};
    tbl[12] = '{8'h81, 8'h59, 8'h59, 8'h09, 1'b1, 5,  32'h8200_0000};
    tbl[13] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 0,  32'h9F7F_7F00};

    #1;
    do_reset();
    chk("reset_tod", tod_o, 32'h0100_0000);
    chk("reset_data", {24'h0, data_o}, 32'h0);
    chk("reset_alrm", {31'h0, alrm_int}, 32'h0);

    todin = 1'b0;
    pin_edges(6);
    chk("div6_six_edges", tod_o, 32'h0100_0001);
    do_reset();
    pin_edges(5);
    chk("div6_five_edges", tod_o, 32'h0100_0000);

    for (int i = 0; i < 14; i++) begin
      todin = tbl[i].tin;
      wr(1'b0, 2'd3, tbl[i].hr);
      wr(1'b0, 2'd2, tbl[i].mn);
      wr(1'b0, 2'd1, tbl[i].sc);
      wr(1'b0, 2'd0, tbl[i].t10);
      pin_edges(tbl[i].edges);
      chk($sformatf("table_%0d", i), tod_o, tbl[i].exp);
    end

    // 11:59:59.9 -> 12 PM, then 12:59:59.9 PM -> 01 PM
    todin = 1'b1;
    wr(1'b0, 2'd3, 8'h11); wr(1'b0, 2'd2, 8'h59); wr(1'b0, 2'd1, 8'h59); wr(1'b0, 2'd0, 8'h09);
    pin_edges(5);
    chk("to_12pm", tod_o, 32'h9200_0000);
    wr(1'b0, 2'd2, 8'h59); wr(1'b0, 2'd1, 8'h59); wr(1'b0, 2'd0, 8'h09);
    pin_edges(5);
    chk("12pm_to_1pm", tod_o, 32'h8100_0000);

    // Hour write stops the clock; 10ths write restarts with a full prescaler period.
    todin = 1'b0;
    wr(1'b0, 2'd0, 8'h00); wr(1'b0, 2'd2, 8'h00); wr(1'b0, 2'd1, 8'h00); wr(1'b0, 2'd3, 8'h05);
    pin_edges(12);
    chk("stopped", tod_o, 32'h0500_0000);
    wr(1'b0, 2'd0, 8'h00);
    pin_edges(5);
    chk("restart_partial", tod_o, 32'h0500_0000);
    pin_edges(1);
    chk("restart_tick", tod_o, 32'h0500_0001);

    // Read latch
    todin = 1'b1;
    wr(1'b0, 2'd3, 8'h03); wr(1'b0, 2'd2, 8'h20); wr(1'b0, 2'd1, 8'h10); wr(1'b0, 2'd0, 8'h00);
    rd(2'd3);
    chk("rd_hr", {24'h0, data_o}, 32'h03);
    pin_edges(100);
    chk("live_after_20", tod_o, 32'h0320_1200);
    rd(2'd1);
    chk("rd_sec_latched", {24'h0, data_o}, 32'h10);
    rd(2'd2);
    chk("rd_min_latched", {24'h0, data_o}, 32'h20);
    rd(2'd0);
    chk("rd_10ths_latched", {24'h0, data_o}, 32'h00);
    rd(2'd1);
    chk("rd_sec_live", {24'h0, data_o}, 32'h12);
    alarm_sel = 1'b0; addr = 2'd1; data_i = 8'h33; we = 1'b1; re = 1'b1;
    cyc();
    chk("rdwr_old_value", {24'h0, data_o}, 32'h12);
    chk("rdwr_new_value", tod_o, 32'h0320_3300);

    // Alarm one-shot
    do_reset();
    pulses = 0;
    wr(1'b1, 2'd0, 8'h01); wr(1'b1, 2'd1, 8'h00); wr(1'b1, 2'd2, 8'h00); wr(1'b1, 2'd3, 8'h01);
    chk("alarm_no_early", pulses, 0);
    todin = 1'b0;
    pin_edges(6);
    chk("alarm_tod", tod_o, 32'h0100_0001);
    chk("alarm_one_pulse", pulses, 1);
    pin_edges(5);
    repeat (10) cyc();
    chk("alarm_no_repeat", pulses, 1);

    // Hour-12 write handling; alarm write of 0x92 is stored as written
    wr(1'b0, 2'd3, 8'h92);
    chk("hr12_counter_write", {24'h0, tod_o[31:24]}, QUIRK ? 32'h12 : 32'h92);
    wr(1'b0, 2'd0, 8'h09); wr(1'b0, 2'd1, 8'h59); wr(1'b0, 2'd2, 8'h59); wr(1'b0, 2'd3, 8'h11);
    wr(1'b1, 2'd0, 8'h00); wr(1'b1, 2'd1, 8'h00); wr(1'b1, 2'd2, 8'h00); wr(1'b1, 2'd3, 8'h92);
    pulses = 0;
    todin = 1'b1;
    wr(1'b0, 2'd0, 8'h09);
    pin_edges(5);
    chk("hr12_alarm_tod", tod_o, 32'h9200_0000);
    chk("hr12_alarm_pulse", pulses, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
